// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage : registered, handshaked RV32 decode stage between fetch and
// execute. Each accepted instruction is decoded combinationally and written
// into a DEPTH-entry output FIFO. The outputs are driven only from the FIFO
// head registers, so there is no combinational path from in_* to out_*, and
// back-pressure from execute never corrupts decoded data.
//
// Optional feature macro: DECODE_RV32M_EN
//   defined   -> R-type funct7 = 0000001 decodes to the RV32M ALU ops
//   undefined -> those encodings are flagged illegal
//
// Parameters
//   XLEN   datapath/PC width (>= 32); immediates are sign-extended to XLEN
//   DEPTH  output FIFO entries (>= 1, any value)
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_flush        drop all buffered entries and the incoming instruction
//   i_in_valid     fetch offers i_in_instr / i_in_pc
//   o_in_ready     stage accepts this cycle
//   i_in_instr     raw 32-bit instruction
//   i_in_pc        instruction PC
//   o_out_valid    head entry valid
//   i_out_ready    execute consumes the head entry
//   o_out_ctrl     decoded control lines (control_signals_t)
//   o_out_imm      sign-extended immediate selected by format
//   o_out_rs1      source register 1 index (raw)
//   o_out_rs2      source register 2 index (raw)
//   o_out_rd       destination register index (raw)
//   o_out_pc       PC of head entry
//   o_out_illegal  head entry is an undecodable instruction
// ---------------------------------------------------------------------------

package decode_pkg;

    typedef enum logic [4:0] {
        OP_ALU_ADD    = 5'd0,
        OP_ALU_SUB    = 5'd1,
        OP_ALU_SLL    = 5'd2,
        OP_ALU_SLT    = 5'd3,
        OP_ALU_SLTU   = 5'd4,
        OP_ALU_XOR    = 5'd5,
        OP_ALU_SRL    = 5'd6,
        OP_ALU_SRA    = 5'd7,
        OP_ALU_OR     = 5'd8,
        OP_ALU_AND    = 5'd9
`ifdef DECODE_RV32M_EN
        ,
        OP_ALU_MUL    = 5'd10,
        OP_ALU_MULH   = 5'd11,
        OP_ALU_MULHSU = 5'd12,
        OP_ALU_MULHU  = 5'd13,
        OP_ALU_DIV    = 5'd14,
        OP_ALU_DIVU   = 5'd15,
        OP_ALU_REM    = 5'd16,
        OP_ALU_REMU   = 5'd17
`endif
    } alu_op_t;

    typedef enum logic [1:0] {
        ALU_RS1_REG  = 2'd0,
        ALU_RS1_ZERO = 2'd1,
        ALU_RS1_PC   = 2'd2
    } alu_rs1_src_t;

    typedef enum logic {
        ALU_REG_OP = 1'b0,
        ALU_IMM_OP = 1'b1
    } alu_rs2_val_t;

    typedef enum logic [1:0] {
        MEM_SKIP_OP  = 2'd0,
        MEM_LOAD_OP  = 2'd1,
        MEM_STORE_OP = 2'd2
    } mem_op_t;

    // PC_REG_DATA writes the link address (pc + 4) for JAL/JALR.
    typedef enum logic [1:0] {
        NO_REG_DATA  = 2'd0,
        ALU_REG_DATA = 2'd1,
        MEM_REG_DATA = 2'd2,
        PC_REG_DATA  = 2'd3
    } reg_file_op_t;

    // Encodings equal the BRANCH funct3 field.
    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } branch_op_t;

    // An all-zero value is the NOP used for illegal instructions.
    typedef struct packed {
        alu_op_t      alu_op;
        alu_rs1_src_t alu_rs1_src;
        alu_rs2_val_t alu_rs2_val;
        mem_op_t      mem_op;
        logic [2:0]   mem_size;
        reg_file_op_t reg_file_op;
        logic         branch_enable;
        branch_op_t   branch_op;
        logic         is_jal;
        logic         is_jalr;
    } control_signals_t;

endpackage

module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_in_instr,
    input  logic [XLEN-1:0]  i_in_pc,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output control_signals_t o_out_ctrl,
    output logic [XLEN-1:0]  o_out_imm,
    output logic [4:0]       o_out_rs1,
    output logic [4:0]       o_out_rs2,
    output logic [4:0]       o_out_rd,
    output logic [XLEN-1:0]  o_out_pc,
    output logic             o_out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        control_signals_t ctrl;
        logic [XLEN-1:0]  imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [XLEN-1:0]  pc;
        logic             illegal;
    } entry_t;

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic [31:0]      w_imm_i;
    logic [31:0]      w_imm_s;
    logic [31:0]      w_imm_b;
    logic [31:0]      w_imm_u;
    logic [31:0]      w_imm_j;
    logic [31:0]      w_imm32;
    logic             w_reserved;
    logic             w_illegal;
    control_signals_t w_ctrl;
    entry_t           w_entry;
    entry_t           w_head;
    logic             w_push;
    logic             w_pop;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    assign w_opcode = i_in_instr[6:0];
    assign w_funct3 = i_in_instr[14:12];
    assign w_funct7 = i_in_instr[31:25];

    assign w_imm_i = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
    assign w_imm_s = {{20{i_in_instr[31]}}, i_in_instr[31:25], i_in_instr[11:7]};
    assign w_imm_b = {{19{i_in_instr[31]}}, i_in_instr[31], i_in_instr[7],
                      i_in_instr[30:25], i_in_instr[11:8], 1'b0};
    assign w_imm_u = {i_in_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_in_instr[31]}}, i_in_instr[31], i_in_instr[19:12],
                      i_in_instr[20], i_in_instr[30:21], 1'b0};

    // Opcode / funct decode. Reserved encodings only raise w_reserved here;
    // the NOP override is applied once when the FIFO entry is assembled.
    always_comb begin
        w_ctrl     = '0;
        w_imm32    = '0;
        w_reserved = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_ctrl.reg_file_op = ALU_REG_DATA;
                case (w_funct7)
                    7'b0000000: begin
                        case (w_funct3)
                            3'b000:  w_ctrl.alu_op = OP_ALU_ADD;
                            3'b001:  w_ctrl.alu_op = OP_ALU_SLL;
                            3'b010:  w_ctrl.alu_op = OP_ALU_SLT;
                            3'b011:  w_ctrl.alu_op = OP_ALU_SLTU;
                            3'b100:  w_ctrl.alu_op = OP_ALU_XOR;
                            3'b101:  w_ctrl.alu_op = OP_ALU_SRL;
                            3'b110:  w_ctrl.alu_op = OP_ALU_OR;
                            default: w_ctrl.alu_op = OP_ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (w_funct3)
                            3'b000:  w_ctrl.alu_op = OP_ALU_SUB;
                            3'b101:  w_ctrl.alu_op = OP_ALU_SRA;
                            default: w_reserved = 1'b1;
                        endcase
                    end
`ifdef DECODE_RV32M_EN
                    7'b0000001: begin
                        case (w_funct3)
                            3'b000:  w_ctrl.alu_op = OP_ALU_MUL;
                            3'b001:  w_ctrl.alu_op = OP_ALU_MULH;
                            3'b010:  w_ctrl.alu_op = OP_ALU_MULHSU;
                            3'b011:  w_ctrl.alu_op = OP_ALU_MULHU;
                            3'b100:  w_ctrl.alu_op = OP_ALU_DIV;
                            3'b101:  w_ctrl.alu_op = OP_ALU_DIVU;
                            3'b110:  w_ctrl.alu_op = OP_ALU_REM;
                            default: w_ctrl.alu_op = OP_ALU_REMU;
                        endcase
                    end
`endif
                    default: w_reserved = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                w_ctrl.reg_file_op = ALU_REG_DATA;
                w_ctrl.alu_rs2_val = ALU_IMM_OP;
                w_imm32            = w_imm_i;
                case (w_funct3)
                    3'b000: w_ctrl.alu_op = OP_ALU_ADD;
                    3'b010: w_ctrl.alu_op = OP_ALU_SLT;
                    3'b011: w_ctrl.alu_op = OP_ALU_SLTU;
                    3'b100: w_ctrl.alu_op = OP_ALU_XOR;
                    3'b110: w_ctrl.alu_op = OP_ALU_OR;
                    3'b111: w_ctrl.alu_op = OP_ALU_AND;
                    3'b001: begin
                        w_ctrl.alu_op = OP_ALU_SLL;
                        w_reserved    = (w_funct7 != 7'b0000000);
                    end
                    default: begin
                        // Shift-right flavour comes from instr[30]; the
                        // remaining funct7 bits must be zero.
                        w_ctrl.alu_op = i_in_instr[30] ? OP_ALU_SRA : OP_ALU_SRL;
                        w_reserved    = ({w_funct7[6], w_funct7[4:0]} != 6'b0);
                    end
                endcase
            end
            OPC_LOAD: begin
                w_ctrl.alu_rs2_val = ALU_IMM_OP;
                w_ctrl.mem_op      = MEM_LOAD_OP;
                w_ctrl.mem_size    = w_funct3;
                w_ctrl.reg_file_op = MEM_REG_DATA;
                w_imm32            = w_imm_i;
                w_reserved         = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                                     (w_funct3 == 3'b111);
            end
            OPC_STORE: begin
                w_ctrl.alu_rs2_val = ALU_IMM_OP;
                w_ctrl.mem_op      = MEM_STORE_OP;
                w_ctrl.mem_size    = w_funct3;
                w_imm32            = w_imm_s;
                w_reserved         = (w_funct3[2] || (w_funct3[1:0] == 2'b11));
            end
            OPC_BRANCH: begin
                w_ctrl.branch_enable = 1'b1;
                w_ctrl.branch_op     = branch_op_t'(w_funct3);
                w_imm32              = w_imm_b;
                w_reserved           = (w_funct3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                w_ctrl.is_jal      = 1'b1;
                w_ctrl.alu_rs1_src = ALU_RS1_PC;
                w_ctrl.alu_rs2_val = ALU_IMM_OP;
                w_ctrl.reg_file_op = PC_REG_DATA;
                w_imm32            = w_imm_j;
            end
            OPC_JALR: begin
                w_ctrl.is_jalr     = 1'b1;
                w_ctrl.alu_rs2_val = ALU_IMM_OP;
                w_ctrl.reg_file_op = PC_REG_DATA;
                w_imm32            = w_imm_i;
                w_reserved         = (w_funct3 != 3'b000);
            end
            OPC_LUI: begin
                w_ctrl.alu_rs1_src = ALU_RS1_ZERO;
                w_ctrl.alu_rs2_val = ALU_IMM_OP;
                w_ctrl.reg_file_op = ALU_REG_DATA;
                w_imm32            = w_imm_u;
            end
            OPC_AUIPC: begin
                w_ctrl.alu_rs1_src = ALU_RS1_PC;
                w_ctrl.alu_rs2_val = ALU_IMM_OP;
                w_ctrl.reg_file_op = ALU_REG_DATA;
                w_imm32            = w_imm_u;
            end
            default: w_reserved = 1'b1;
        endcase
    end

    assign w_illegal = w_reserved || (i_in_instr[1:0] != 2'b11);

    // Illegal entries carry a NOP control word and a zero immediate;
    // register indices and PC always pass through untouched.
    always_comb begin
        w_entry.ctrl    = w_illegal ? control_signals_t'('0) : w_ctrl;
        w_entry.imm     = w_illegal ? '0 : XLEN'($signed(w_imm32));
        w_entry.rs1     = i_in_instr[19:15];
        w_entry.rs2     = i_in_instr[24:20];
        w_entry.rd      = i_in_instr[11:7];
        w_entry.pc      = i_in_pc;
        w_entry.illegal = w_illegal;
    end

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    assign o_out_valid = (r_count != '0);
    assign o_in_ready  = (r_count < DEPTH_CNT) && !i_flush;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready && !i_flush;

    // FIFO storage and pointers. Entries are cleared on reset so that every
    // data output reads zero while reset is held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_entry;
                r_tail        <= nextPtr(r_tail);
            end
            if (w_pop) begin
                r_head <= nextPtr(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head        = r_mem[r_head];
    assign o_out_ctrl    = w_head.ctrl;
    assign o_out_imm     = w_head.imm;
    assign o_out_rs1     = w_head.rs1;
    assign o_out_rs2     = w_head.rs2;
    assign o_out_rd      = w_head.rd;
    assign o_out_pc      = w_head.pc;
    assign o_out_illegal = w_head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage : self-checking bench for decode_stage.
// Directed vector table, hand-written reset / back-pressure / flush
// sequences, then randomized traffic against a queue-based reference model.
// Honours DECODE_RV32M_EN the same way as the design.
// ---------------------------------------------------------------------------

module tb_decode_stage;
    import decode_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic             illegal;
        control_signals_t ctrl;
        logic [31:0]      imm;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [31:0]      pc;
    } expT;

    typedef struct {
        logic [31:0]      instr;
        logic             expIllegal;
        logic [31:0]      expImm;
        control_signals_t expCtrl;
    } vecT;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             inValid;
    logic             inReady;
    logic [31:0]      inInstr;
    logic [31:0]      inPc;
    logic             outValid;
    logic             outReady;
    control_signals_t outCtrl;
    logic [31:0]      outImm;
    logic [4:0]       outRs1;
    logic [4:0]       outRs2;
    logic [4:0]       outRd;
    logic [31:0]      outPc;
    logic             outIllegal;

    int checks = 0;
    int errors = 0;

    decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_in_valid   (inValid),
        .o_in_ready   (inReady),
        .i_in_instr   (inInstr),
        .i_in_pc      (inPc),
        .o_out_valid  (outValid),
        .i_out_ready  (outReady),
        .o_out_ctrl   (outCtrl),
        .o_out_imm    (outImm),
        .o_out_rs1    (outRs1),
        .o_out_rs2    (outRs2),
        .o_out_rd     (outRd),
        .o_out_pc     (outPc),
        .o_out_illegal(outIllegal)
    );

    always #5 clk = ~clk;

    function automatic control_signals_t ctrlOf(
        input alu_op_t a, input alu_rs1_src_t s1, input alu_rs2_val_t s2,
        input mem_op_t m, input logic [2:0] sz, input reg_file_op_t r,
        input logic be, input branch_op_t bo, input logic j, input logic jr);
        control_signals_t c;
        c.alu_op        = a;
        c.alu_rs1_src   = s1;
        c.alu_rs2_val   = s2;
        c.mem_op        = m;
        c.mem_size      = sz;
        c.reg_file_op   = r;
        c.branch_enable = be;
        c.branch_op     = bo;
        c.is_jal        = j;
        c.is_jalr       = jr;
        return c;
    endfunction

    // Reference decode written from the ISA tables: pick the mnemonic's
    // control recipe, then blank everything if the encoding is not legal.
    function automatic expT refDecode(input logic [31:0] ins, input logic [31:0] pc);
        expT e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok;
        alu_op_t baseAlu [8];
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        baseAlu = '{OP_ALU_ADD, OP_ALU_SLL, OP_ALU_SLT, OP_ALU_SLTU,
                    OP_ALU_XOR, OP_ALU_SRL, OP_ALU_OR, OP_ALU_AND};
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.pc  = pc;
        e.imm = 32'($signed(ins[31:20]));
        e.ctrl = ctrlOf(OP_ALU_ADD, ALU_RS1_REG, ALU_IMM_OP, MEM_SKIP_OP, 3'd0,
                        ALU_REG_DATA, 1'b0, BR_EQ, 1'b0, 1'b0);
        ok = 1'b0;
        if (op == 7'h33) begin
            e.imm = 32'd0;
            e.ctrl.alu_rs2_val = ALU_REG_OP;
            if (f7 == 7'h00) begin
                ok = 1'b1;
                e.ctrl.alu_op = baseAlu[f3];
            end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                ok = 1'b1;
                e.ctrl.alu_op = (f3 == 3'd0) ? OP_ALU_SUB : OP_ALU_SRA;
            end
`ifdef DECODE_RV32M_EN
            else if (f7 == 7'h01) begin
                ok = 1'b1;
                e.ctrl.alu_op = alu_op_t'(5'd10 + 5'(f3));
            end
`endif
        end else if (op == 7'h13) begin
            e.ctrl.alu_op = baseAlu[f3];
            ok = 1'b1;
            if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
            if (f3 == 3'd5) begin
                if (f7 == 7'h20) e.ctrl.alu_op = OP_ALU_SRA;
                else if (f7 != 7'h00) ok = 1'b0;
            end
        end else if (op == 7'h03) begin
            ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            e.ctrl.mem_op = MEM_LOAD_OP;
            e.ctrl.mem_size = f3;
            e.ctrl.reg_file_op = MEM_REG_DATA;
        end else if (op == 7'h23) begin
            ok = (f3 <= 3'd2);
            e.ctrl.mem_op = MEM_STORE_OP;
            e.ctrl.mem_size = f3;
            e.ctrl.reg_file_op = NO_REG_DATA;
            e.imm = 32'($signed({ins[31:25], ins[11:7]}));
        end else if (op == 7'h63) begin
            ok = !(f3 == 3'd2 || f3 == 3'd3);
            e.ctrl = ctrlOf(OP_ALU_ADD, ALU_RS1_REG, ALU_REG_OP, MEM_SKIP_OP, 3'd0,
                            NO_REG_DATA, 1'b1, branch_op_t'(f3), 1'b0, 1'b0);
            e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        end else if (op == 7'h6F) begin
            ok = 1'b1;
            e.ctrl.alu_rs1_src = ALU_RS1_PC;
            e.ctrl.reg_file_op = PC_REG_DATA;
            e.ctrl.is_jal = 1'b1;
            e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        end else if (op == 7'h67) begin
            ok = (f3 == 3'd0);
            e.ctrl.reg_file_op = PC_REG_DATA;
            e.ctrl.is_jalr = 1'b1;
        end else if (op == 7'h37 || op == 7'h17) begin
            ok = 1'b1;
            e.ctrl.alu_rs1_src = (op == 7'h37) ? ALU_RS1_ZERO : ALU_RS1_PC;
            e.imm = ins & 32'hFFFF_F000;
        end
        e.illegal = !ok;
        if (!ok) begin
            e.ctrl = '0;
            e.imm  = 32'd0;
        end
        return e;
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] ins;
        logic [6:0]  opcodes [9];
        int kind;
        opcodes = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        ins  = $urandom();
        kind = $urandom_range(0, 10);
        if (kind < 9) begin
            ins[6:0] = opcodes[kind];
            case ($urandom_range(0, 3))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                2: ins[31:25] = 7'h01;
                default: ;
            endcase
        end else if (kind == 10) begin
            ins[1:0] = 2'($urandom_range(0, 2));
        end
        return ins;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input expT e);
        checkVal({tag, ".valid"},   64'(outValid),   64'(1'b1));
        checkVal({tag, ".illegal"}, 64'(outIllegal), 64'(e.illegal));
        checkVal({tag, ".ctrl"},    64'(outCtrl),    64'(e.ctrl));
        checkVal({tag, ".imm"},     64'(outImm),     64'(e.imm));
        checkVal({tag, ".rd"},      64'(outRd),      64'(e.rd));
        checkVal({tag, ".rs1"},     64'(outRs1),     64'(e.rs1));
        checkVal({tag, ".rs2"},     64'(outRs2),     64'(e.rs2));
        checkVal({tag, ".pc"},      64'(outPc),      64'(e.pc));
    endtask

    task automatic checkZero(input string tag);
        checkVal({tag, ".valid"},   64'(outValid),   64'd0);
        checkVal({tag, ".illegal"}, 64'(outIllegal), 64'd0);
        checkVal({tag, ".ctrl"},    64'(outCtrl),    64'd0);
        checkVal({tag, ".imm"},     64'(outImm),     64'd0);
        checkVal({tag, ".rd"},      64'(outRd),      64'd0);
        checkVal({tag, ".rs1"},     64'(outRs1),     64'd0);
        checkVal({tag, ".rs2"},     64'(outRs2),     64'd0);
        checkVal({tag, ".pc"},      64'(outPc),      64'd0);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic ordy, input logic fl);
        inValid  = v;
        inInstr  = ins;
        inPc     = pc;
        outReady = ordy;
        flush    = fl;
    endtask

    initial begin
        vecT vecs [14];
        expT e;
        expT exA;
        expT exB;
        expT exC;
        expT q [$];
        control_signals_t nop;
        logic v;
        logic fl;
        logic ordy;
        logic [31:0] ins;
        logic [31:0] pc;
        logic pushOk;
        logic popOk;

        nop = '0;
        vecs[0]  = '{32'hFFB10093, 1'b0, 32'hFFFFFFFB, ctrlOf(OP_ALU_ADD, ALU_RS1_REG, ALU_IMM_OP,
                     MEM_SKIP_OP, 3'd0, ALU_REG_DATA, 1'b0, BR_EQ, 1'b0, 1'b0)};
        vecs[1]  = '{32'h00512423, 1'b0, 32'h00000008, ctrlOf(OP_ALU_ADD, ALU_RS1_REG, ALU_IMM_OP,
                     MEM_STORE_OP, 3'd2, NO_REG_DATA, 1'b0, BR_EQ, 1'b0, 1'b0)};
        vecs[2]  = '{32'h0040A183, 1'b0, 32'h00000004, ctrlOf(OP_ALU_ADD, ALU_RS1_REG, ALU_IMM_OP,
                     MEM_LOAD_OP, 3'd2, MEM_REG_DATA, 1'b0, BR_EQ, 1'b0, 1'b0)};
        vecs[3]  = '{32'h00209863, 1'b0, 32'h00000010, ctrlOf(OP_ALU_ADD, ALU_RS1_REG, ALU_REG_OP,
                     MEM_SKIP_OP, 3'd0, NO_REG_DATA, 1'b1, BR_NE, 1'b0, 1'b0)};
        vecs[4]  = '{32'hFE000EE3, 1'b0, 32'hFFFFFFFC, ctrlOf(OP_ALU_ADD, ALU_RS1_REG, ALU_REG_OP,
                     MEM_SKIP_OP, 3'd0, NO_REG_DATA, 1'b1, BR_EQ, 1'b0, 1'b0)};
        vecs[5]  = '{32'h008000EF, 1'b0, 32'h00000008, ctrlOf(OP_ALU_ADD, ALU_RS1_PC, ALU_IMM_OP,
                     MEM_SKIP_OP, 3'd0, PC_REG_DATA, 1'b0, BR_EQ, 1'b1, 1'b0)};
        vecs[6]  = '{32'h00008067, 1'b0, 32'h00000000, ctrlOf(OP_ALU_ADD, ALU_RS1_REG, ALU_IMM_OP,
                     MEM_SKIP_OP, 3'd0, PC_REG_DATA, 1'b0, BR_EQ, 1'b0, 1'b1)};
        vecs[7]  = '{32'h123452B7, 1'b0, 32'h12345000, ctrlOf(OP_ALU_ADD, ALU_RS1_ZERO, ALU_IMM_OP,
                     MEM_SKIP_OP, 3'd0, ALU_REG_DATA, 1'b0, BR_EQ, 1'b0, 1'b0)};
        vecs[8]  = '{32'hFFFFF317, 1'b0, 32'hFFFFF000, ctrlOf(OP_ALU_ADD, ALU_RS1_PC, ALU_IMM_OP,
                     MEM_SKIP_OP, 3'd0, ALU_REG_DATA, 1'b0, BR_EQ, 1'b0, 1'b0)};
        vecs[9]  = '{32'h402081B3, 1'b0, 32'h00000000, ctrlOf(OP_ALU_SUB, ALU_RS1_REG, ALU_REG_OP,
                     MEM_SKIP_OP, 3'd0, ALU_REG_DATA, 1'b0, BR_EQ, 1'b0, 1'b0)};
        vecs[10] = '{32'h40315093, 1'b0, 32'h00000403, ctrlOf(OP_ALU_SRA, ALU_RS1_REG, ALU_IMM_OP,
                     MEM_SKIP_OP, 3'd0, ALU_REG_DATA, 1'b0, BR_EQ, 1'b0, 1'b0)};
        vecs[11] = '{32'h02109093, 1'b1, 32'h00000000, nop};
`ifdef DECODE_RV32M_EN
        vecs[12] = '{32'h02208033, 1'b0, 32'h00000000, ctrlOf(OP_ALU_MUL, ALU_RS1_REG, ALU_REG_OP,
                     MEM_SKIP_OP, 3'd0, ALU_REG_DATA, 1'b0, BR_EQ, 1'b0, 1'b0)};
`else
        vecs[12] = '{32'h02208033, 1'b1, 32'h00000000, nop};
`endif
        vecs[13] = '{32'h00000000, 1'b1, 32'h00000000, nop};

        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkZero("reset");
        rst = 1'b0;
        #1;
        checkVal("reset.inReady", 64'(inReady), 64'd1);

        $display("[TB] directed vectors");
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
            @(negedge clk);
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
            e.illegal = vecs[i].expIllegal;
            e.ctrl    = vecs[i].expCtrl;
            e.imm     = vecs[i].expImm;
            ins       = vecs[i].instr;
            e.rd      = ins[11:7];
            e.rs1     = ins[19:15];
            e.rs2     = ins[24:20];
            e.pc      = 32'h1000 + 32'(i * 4);
            checkOutput($sformatf("vec%0d", i), e);
        end

        $display("[TB] back-pressure ordering");
        exA = refDecode(32'hFFB10093, 32'h200);
        exB = refDecode(32'h00512423, 32'h204);
        exC = refDecode(32'h123452B7, 32'h208);
        @(negedge clk);
        applyStimulus(1'b1, 32'hFFB10093, 32'h200, 1'b0, 1'b0);
        @(negedge clk);
        checkVal("bp.readyAfter1", 64'(inReady), 64'd1);
        applyStimulus(1'b1, 32'h00512423, 32'h204, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h123452B7, 32'h208, 1'b0, 1'b0);
        #1;
        checkVal("bp.readyFull", 64'(inReady), 64'd0);
        checkOutput("bp.headA", exA);
        @(negedge clk);
        checkOutput("bp.holdA", exA);
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("bp.headB", exB);
        checkVal("bp.readyPop", 64'(inReady), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("bp.headC", exC);
        @(negedge clk);
        checkVal("bp.drained", 64'(outValid), 64'd0);

        $display("[TB] flush");
        applyStimulus(1'b1, 32'hFFB10093, 32'h300, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h00512423, 32'h304, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h123452B7, 32'h308, 1'b1, 1'b1);
        #1;
        checkVal("flush.inReady", 64'(inReady), 64'd0);
        @(negedge clk);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        checkVal("flush.valid", 64'(outValid), 64'd0);
        checkVal("flush.readyAfter", 64'(inReady), 64'd1);
        repeat (2) @(negedge clk);
        checkVal("flush.dropped", 64'(outValid), 64'd0);

        $display("[TB] randomized traffic");
        q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            v    = ($urandom_range(0, 99) < 60);
            ins  = randInstr();
            pc   = $urandom() & 32'hFFFF_FFFC;
            ordy = ($urandom_range(0, 99) < 65);
            fl   = ($urandom_range(0, 39) == 0);
            applyStimulus(v, ins, pc, ordy, fl);
            #1;
            checkVal("rand.inReady", 64'(inReady), 64'((q.size() < DEPTH) && !fl));
            if (q.size() > 0) checkOutput("rand", q[0]);
            else checkVal("rand.valid", 64'(outValid), 64'd0);
            pushOk = v && (q.size() < DEPTH) && !fl;
            popOk  = (q.size() > 0) && ordy && !fl;
            if (fl) begin
                q.delete();
            end else begin
                if (popOk) void'(q.pop_front());
                if (pushOk) q.push_back(refDecode(ins, pc));
            end
        end

        $display("[TB] reset mid-stream");
        @(negedge clk);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 32'h0040A183, 32'h400, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h008000EF, 32'h404, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkVal("midrst.filled", 64'(outValid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkZero("midrst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("midrst.inReady", 64'(inReady), 64'd1);
        checkVal("midrst.empty", 64'(outValid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
